// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch redirect controller.
// FSM state encoding, BHT reset value, PC step and 2-bit saturating counter math.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [1:0]  BHT_RESET = 2'b01;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    if (ctr == 2'b11) begin
      return 2'b11;
    end else begin
      return ctr + 2'b01;
    end
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    if (ctr == 2'b00) begin
      return 2'b00;
    end else begin
      return ctr - 2'b01;
    end
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage resolution / fetch redirect bundle of the branch redirect controller.
// master = branch unit + fetch side, slave = branch_redirect_ctrl.
interface branch_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_is_jump;
  logic            ex_br_taken;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            busy;

  modport master (
    output stall, ex_valid, ex_is_branch, ex_is_jump, ex_br_taken,
           ex_pred_taken, ex_pc, ex_target, if_pc,
    input  pred_taken, redirect_valid, redirect_pc, flush_if_id,
           flush_id_ex, busy
  );

  modport slave (
    input  stall, ex_valid, ex_is_branch, ex_is_jump, ex_br_taken,
           ex_pred_taken, ex_pc, ex_target, if_pc,
    output pred_taken, redirect_valid, redirect_pc, flush_if_id,
           flush_id_ex, busy
  );
endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters, one lookup and one update port.
// A same-cycle lookup of the index being updated sees the pre-update counter.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic [1:0]       lookup_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] ctr_r [ENTRIES];

  // Counter array: reset to weakly not-taken, train on resolved conditional branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      ctr_r[upd_idx] <= upd_taken ? sat_inc(ctr_r[upd_idx]) : sat_dec(ctr_r[upd_idx]);
    end else begin
      ctr_r <= ctr_r;
    end
  end

  assign lookup_ctr = ctr_r[lookup_idx];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer: mispredict detection, PC redirect and pipeline flush.
// Define BRANCH_PRED_EN to add a 2-bit BHT; otherwise prediction is static not-taken.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_redirect_ctrl_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e          state_r;
  logic [CNT_W-1:0] cnt_r;
  logic            actual_s;
  logic            mispredict_s;
  logic            accept_s;
  logic [XLEN-1:0] correct_pc_s;

  // A jump wins over a simultaneously flagged branch.
  assign actual_s     = bus.ex_is_jump | (bus.ex_is_branch & bus.ex_br_taken);
  assign mispredict_s = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump) &
                        (actual_s != bus.ex_pred_taken);
  assign accept_s     = (state_r == IDLE) & bus.ex_valid & ~bus.stall;
  assign correct_pc_s = actual_s ? bus.ex_target : bus.ex_pc + XLEN'(PC_STEP);

`ifdef BRANCH_PRED_EN
  logic [1:0] pred_ctr_s;
  logic       unused_s;

  bht_2bit #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_idx (bus.if_pc[BHT_IDX_W+1:2]),
    .lookup_ctr (pred_ctr_s),
    .upd_en     (accept_s & bus.ex_is_branch & ~bus.ex_is_jump),
    .upd_idx    (bus.ex_pc[BHT_IDX_W+1:2]),
    .upd_taken  (bus.ex_br_taken)
  );

  assign bus.pred_taken = pred_ctr_s[1];
  assign unused_s       = ^{bus.if_pc, bus.ex_pc, pred_ctr_s};
`else
  logic unused_s;

  assign bus.pred_taken = 1'b0;
  assign unused_s       = ^bus.if_pc;
`endif

  // Redirect/flush sequencer; all outputs registered and held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      cnt_r              <= {CNT_W{1'b0}};
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= {XLEN{1'b0}};
      bus.flush_if_id    <= 1'b0;
      bus.flush_id_ex    <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && mispredict_s) begin
            state_r            <= REDIRECT;
            bus.redirect_pc    <= correct_pc_s;
            bus.redirect_valid <= 1'b1;
            bus.flush_if_id    <= 1'b1;
            bus.flush_id_ex    <= 1'b1;
            bus.busy           <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        REDIRECT: begin
          if (bus.stall) begin
            state_r <= REDIRECT;
          end else if (FLUSH_CYCLES == 1) begin
            state_r            <= IDLE;
            bus.redirect_valid <= 1'b0;
            bus.flush_if_id    <= 1'b0;
            bus.flush_id_ex    <= 1'b0;
            bus.busy           <= 1'b0;
          end else begin
            state_r            <= FLUSH;
            cnt_r              <= CNT_W'(FLUSH_CYCLES - 1);
            bus.redirect_valid <= 1'b0;
            bus.flush_id_ex    <= 1'b0;
          end
        end
        FLUSH: begin
          if (bus.stall) begin
            state_r <= FLUSH;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            state_r         <= IDLE;
            bus.flush_if_id <= 1'b0;
            bus.busy        <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r            <= IDLE;
          cnt_r              <= {CNT_W{1'b0}};
          bus.redirect_valid <= 1'b0;
          bus.flush_if_id    <= 1'b0;
          bus.flush_id_ex    <= 1'b0;
          bus.busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl (BHT scenario only with BRANCH_PRED_EN).
module tb_branch_redirect_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_redirect_ctrl_if #(.XLEN(32)) bus ();

  branch_redirect_ctrl #(
    .XLEN         (32),
    .BHT_IDX_W    (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {redirect_valid, flush_if_id, flush_id_ex, busy}
  logic [3:0] outs;
  assign outs = {bus.redirect_valid, bus.flush_if_id, bus.flush_id_ex, bus.busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic jmp, input logic tk,
                       input logic pr, input logic [31:0] pc, input logic [31:0] tgt);
    bus.ex_valid      = v;
    bus.ex_is_branch  = br;
    bus.ex_is_jump    = jmp;
    bus.ex_br_taken   = tk;
    bus.ex_pred_taken = pr;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    bus.if_pc = 32'h0000_0040;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: got %b want %b", outs, 4'b0000);
    end
    checks++;
    if (bus.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h want %h", bus.redirect_pc, 32'h0);
    end
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred: got %b want %b", bus.pred_taken, 1'b0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_taken_mispredict();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b1111;
    exp_seq[1] = 4'b0101;
    exp_seq[2] = 4'b0101;
    exp_seq[3] = 4'b0000;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0180);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL beq_pre_busy: got %b want %b", bus.busy, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (outs !== exp_seq[i]) begin
        errors++;
        $display("FAIL beq_seq[%0d]: got %b want %b", i, outs, exp_seq[i]);
      end
      if (i == 0) begin
        checks++;
        if (bus.redirect_pc !== 32'h0000_0180) begin
          errors++;
          $display("FAIL beq_pc: got %h want %h", bus.redirect_pc, 32'h0000_0180);
        end
      end
    end
  endtask

  task automatic test_not_taken_mispredict();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0280);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (outs !== 4'b1111 || bus.redirect_pc !== 32'h0000_0204) begin
      errors++;
      $display("FAIL bne_redirect: got %b/%h want %b/%h", outs, bus.redirect_pc, 4'b1111, 32'h0000_0204);
    end
    tick();
    tick();
    tick();
    // Correct not-taken and correct taken predictions: no action.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0280);
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL bne_correct_nt: got %b want %b", outs, 4'b0000);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0210, 32'h0000_0300);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL correct_taken: got %b want %b", outs, 4'b0000);
    end
  endtask

  task automatic test_stall_hold();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0340);
    tick();
    bus.stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_05A0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== 4'b1111 || bus.redirect_pc !== 32'h0000_0340) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %b/%h want %b/%h", i, outs, bus.redirect_pc, 4'b1111, 32'h0000_0340);
      end
    end
    bus.stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== 4'b0101 || bus.redirect_pc !== 32'h0000_0340) begin
        errors++;
        $display("FAIL stall_flush[%0d]: got %b/%h want %b/%h", i, outs, bus.redirect_pc, 4'b0101, 32'h0000_0340);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL stall_idle: got %b want %b", outs, 4'b0000);
    end
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL stall_no_retrigger: got %b want %b", outs, 4'b0000);
    end
  endtask

  task automatic test_wrap_and_jump();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_1000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (outs !== 4'b1111 || bus.redirect_pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: got %b/%h want %b/%h", outs, bus.redirect_pc, 4'b1111, 32'h0000_0000);
    end
    tick();
    tick();
    tick();
    // Branch and jump both flagged, branch not taken: behaves as a jump.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0000_0640);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (outs !== 4'b1111 || bus.redirect_pc !== 32'h0000_0640) begin
      errors++;
      $display("FAIL jump_prio: got %b/%h want %b/%h", outs, bus.redirect_pc, 4'b1111, 32'h0000_0640);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'h0000_0800);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (outs !== 4'b0101) begin
      errors++;
      $display("FAIL rst_pre_flush: got %b want %b", outs, 4'b0101);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 4'b0000 || bus.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: got %b/%h want %b/%h", outs, bus.redirect_pc, 4'b0000, 32'h0);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL rst_idle: got %b want %b", outs, 4'b0000);
    end
  endtask

`ifdef BRANCH_PRED_EN
  task automatic test_bht();
    logic exp_pred [7];
    exp_pred[0] = 1'b1;
    exp_pred[1] = 1'b1;
    exp_pred[2] = 1'b1;
    exp_pred[3] = 1'b1;
    exp_pred[4] = 1'b0;
    exp_pred[5] = 1'b0;
    exp_pred[6] = 1'b0;
    bus.if_pc = 32'h0000_0040;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0080);
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL bht_pre_update: got %b want %b", bus.pred_taken, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0080);
      end
      tick();
      checks++;
      if (bus.pred_taken !== exp_pred[i] || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL bht_step[%0d]: got %b/%b want %b/%b", i, bus.pred_taken, bus.busy, exp_pred[i], 1'b0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.if_pc = 32'h0000_0044;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL bht_other_idx: got %b want %b", bus.pred_taken, 1'b0);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_taken_mispredict();
    test_not_taken_mispredict();
    test_stall_hold();
    test_wrap_and_jump();
    test_async_reset();
`ifdef BRANCH_PRED_EN
    test_bht();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
